// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI-Lite codes, host command ops, FSM states and GCP register map
package axil_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // Reserved encoding executes as a plain read.
    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_POLL  = 2'b10,
        OP_RSVD  = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_POLL_WAIT,
        ST_RSP
    } state_e;

    localparam logic [11:0] GCP_CTRL       = 12'h000;
    localparam logic [11:0] GCP_STATUS     = 12'h004;
    localparam logic [11:0] GCP_IRQ_EN     = 12'h008;
    localparam logic [11:0] GCP_IRQ_STATUS = 12'h00C;
    localparam logic [11:0] GCP_TPC_BASE   = 12'h100;
    localparam logic [11:0] GCP_TPC_STRIDE = 12'h010;

endpackage

// File: rtl/axil_host_master_if.sv
// rtl/axil_host_master_if.sv - AXI-Lite bus between the host master and a register slave
interface axil_host_master_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m_axi_awaddr;
    logic                m_axi_awvalid;
    logic                m_axi_awready;
    logic [DATA_W-1:0]   m_axi_wdata;
    logic [DATA_W/8-1:0] m_axi_wstrb;
    logic                m_axi_wvalid;
    logic                m_axi_wready;
    logic [1:0]          m_axi_bresp;
    logic                m_axi_bvalid;
    logic                m_axi_bready;
    logic [ADDR_W-1:0]   m_axi_araddr;
    logic                m_axi_arvalid;
    logic                m_axi_arready;
    logic [DATA_W-1:0]   m_axi_rdata;
    logic [1:0]          m_axi_rresp;
    logic                m_axi_rvalid;
    logic                m_axi_rready;

    modport master (
        output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );
endinterface

// File: rtl/axil_host_master.sv
// rtl/axil_host_master.sv - host command to AXI-Lite write/read/poll master, one command in flight
module axil_host_master
    import axil_pkg::*;
#(
    parameter int AXI_ADDR_W = 12,
    parameter int AXI_DATA_W = 32,
    parameter int POLL_MAX   = 1024,
    parameter int POLL_GAP   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [AXI_ADDR_W-1:0] cmd_addr,
    input  logic [AXI_DATA_W-1:0] cmd_data,
    input  logic [AXI_DATA_W-1:0] cmd_mask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [AXI_DATA_W-1:0] rsp_data,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic                  busy,
    axil_host_master_if.master    axi
);

    localparam int ATT_W = $clog2(POLL_MAX + 1);
    localparam int GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [ATT_W-1:0] ATT_LAST = ATT_W'(POLL_MAX);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    state_e                state;
    cmd_op_e               op_q;
    logic [AXI_DATA_W-1:0] data_q;
    logic [AXI_DATA_W-1:0] mask_q;
    logic [ATT_W-1:0]      attempts;
    logic [GAP_W-1:0]      gap_cnt;

    logic [AXI_ADDR_W-1:0] awaddr;
    logic                  awvalid;
    logic [AXI_DATA_W-1:0] wdata;
    logic                  wvalid;
    logic                  bready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic                  arvalid;
    logic                  rready;
    logic                  poll_hit;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = !cmd_ready;

    assign axi.m_axi_awaddr  = awaddr;
    assign axi.m_axi_awvalid = awvalid;
    assign axi.m_axi_wdata   = wdata;
    assign axi.m_axi_wstrb   = '1;
    assign axi.m_axi_wvalid  = wvalid;
    assign axi.m_axi_bready  = bready;
    assign axi.m_axi_araddr  = araddr;
    assign axi.m_axi_arvalid = arvalid;
    assign axi.m_axi_rready  = rready;

    assign poll_hit = ((axi.m_axi_rdata ^ data_q) & mask_q) == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_q        <= OP_WRITE;
            data_q      <= '0;
            mask_q      <= '0;
            attempts    <= '0;
            gap_cnt     <= '0;
            awaddr      <= '0;
            awvalid     <= 1'b0;
            wdata       <= '0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            araddr      <= '0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op_e'(cmd_op);
                        data_q   <= cmd_data;
                        mask_q   <= cmd_mask;
                        attempts <= '0;
                        if (cmd_op_e'(cmd_op) == OP_WRITE) begin
                            awaddr  <= cmd_addr;
                            wdata   <= cmd_data;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= ST_WR;
                        end else begin
                            araddr  <= cmd_addr;
                            arvalid <= 1'b1;
                            state   <= ST_RD_ADDR;
                        end
                    end
                end

                // AW and W retire independently; a channel already done counts as complete.
                ST_WR: begin
                    if (awvalid && axi.m_axi_awready) awvalid <= 1'b0;
                    if (wvalid && axi.m_axi_wready)   wvalid  <= 1'b0;
                    if ((!awvalid || axi.m_axi_awready) && (!wvalid || axi.m_axi_wready)) begin
                        bready <= 1'b1;
                        state  <= ST_WR_RESP;
                    end
                end

                ST_WR_RESP: begin
                    if (axi.m_axi_bvalid && bready) begin
                        bready      <= 1'b0;
                        rsp_resp    <= axi.m_axi_bresp;
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RSP;
                    end
                end

                ST_RD_ADDR: begin
                    if (axi.m_axi_arready) begin
                        arvalid  <= 1'b0;
                        rready   <= 1'b1;
                        attempts <= attempts + 1'b1;
                        state    <= ST_RD_DATA;
                    end
                end

                // Error responses and matches end a poll before the attempt limit is considered.
                ST_RD_DATA: begin
                    if (axi.m_axi_rvalid && rready) begin
                        rready      <= 1'b0;
                        rsp_data    <= axi.m_axi_rdata;
                        rsp_resp    <= axi.m_axi_rresp;
                        rsp_timeout <= 1'b0;
                        if (op_q != OP_POLL || axi.m_axi_rresp != RESP_OKAY || poll_hit) begin
                            rsp_valid <= 1'b1;
                            state     <= ST_RSP;
                        end else if (attempts == ATT_LAST) begin
                            rsp_timeout <= 1'b1;
                            rsp_valid   <= 1'b1;
                            state       <= ST_RSP;
                        end else if (POLL_GAP == 0) begin
                            arvalid <= 1'b1;
                            state   <= ST_RD_ADDR;
                        end else begin
                            gap_cnt <= '0;
                            state   <= ST_POLL_WAIT;
                        end
                    end
                end

                ST_POLL_WAIT: begin
                    if (gap_cnt == GAP_LAST) begin
                        arvalid <= 1'b1;
                        state   <= ST_RD_ADDR;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_host_master.sv
// tb/tb_axil_host_master.sv - directed bench for axil_host_master with a configurable register slave
module tb_axil_host_master;
    import axil_pkg::*;

    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int PMAX = 4;
    localparam int PGAP = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic [DW-1:0] cmd_mask = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axil_host_master_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

    axil_host_master #(
        .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .POLL_MAX(PMAX), .POLL_GAP(PGAP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .axi(axi)
    );

    // Slave configuration, written only by the stimulus block.
    int         aw_wait = 0;
    int         w_wait = 0;
    int         status_set_at = 0;
    int         err_at = 0;
    logic [1:0] bresp_cfg = 2'b00;
    logic       r_stall = 1'b0;
    logic       cmd_clr = 1'b0;

    logic          aw_got, w_got, r_pend, rvalid_q;
    logic [AW-1:0] aw_a;
    logic [DW-1:0] w_d, rdata_q;
    logic [3:0]    w_s;
    logic [1:0]    rresp_q;
    int aw_c, w_c, aw_hs, w_hs, b_hs, ar_hs, ar_n, aw_hs_cyc, b_hs_cyc, last_ar, min_gap;
    logic [DW-1:0] mem [0:1023];

    // STATUS: bit16 appears from read number status_set_at of the current command; low byte = read number.
    function automatic logic [DW-1:0] slave_rdata(input logic [AW-1:0] a, input int n);
        if (a == GCP_STATUS)
            return ((status_set_at != 0 && n >= status_set_at) ? 32'h0001_0000 : 32'h0) | 32'(n);
        return mem[a[11:2]];
    endfunction

    assign axi.m_axi_awready = axi.m_axi_awvalid && !aw_got && (aw_c >= aw_wait);
    assign axi.m_axi_wready  = axi.m_axi_wvalid && !w_got && (w_c >= w_wait);
    assign axi.m_axi_bvalid  = aw_got && w_got;
    assign axi.m_axi_bresp   = bresp_cfg;
    assign axi.m_axi_arready = !r_pend && !rvalid_q;
    assign axi.m_axi_rvalid  = rvalid_q;
    assign axi.m_axi_rdata   = rdata_q;
    assign axi.m_axi_rresp   = rresp_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0; rvalid_q <= 1'b0;
            aw_a <= '0; w_d <= '0; w_s <= '0; rdata_q <= '0; rresp_q <= '0;
            aw_c <= 0; w_c <= 0; aw_hs <= 0; w_hs <= 0; b_hs <= 0; ar_hs <= 0; ar_n <= 0;
            aw_hs_cyc <= 0; b_hs_cyc <= 0; last_ar <= -1; min_gap <= 1000000;
        end else begin
            if (axi.m_axi_awvalid && axi.m_axi_awready) begin
                aw_got <= 1'b1; aw_a <= axi.m_axi_awaddr; aw_c <= 0;
                aw_hs <= aw_hs + 1; aw_hs_cyc <= cyc;
            end else if (axi.m_axi_awvalid) begin
                aw_c <= aw_c + 1;
            end
            if (axi.m_axi_wvalid && axi.m_axi_wready) begin
                w_got <= 1'b1; w_d <= axi.m_axi_wdata; w_s <= axi.m_axi_wstrb; w_c <= 0;
                w_hs <= w_hs + 1;
            end else if (axi.m_axi_wvalid) begin
                w_c <= w_c + 1;
            end
            if (axi.m_axi_bvalid && axi.m_axi_bready) begin
                aw_got <= 1'b0; w_got <= 1'b0; b_hs <= b_hs + 1; b_hs_cyc <= cyc;
                mem[aw_a[11:2]] <= w_d;
            end
            if (axi.m_axi_arvalid && axi.m_axi_arready) begin
                ar_hs   <= ar_hs + 1;
                ar_n    <= ar_n + 1;
                r_pend  <= 1'b1;
                rdata_q <= slave_rdata(axi.m_axi_araddr, ar_n + 1);
                rresp_q <= (ar_n + 1 == err_at) ? 2'b11 : 2'b00;
                if (last_ar >= 0 && cyc - last_ar < min_gap) min_gap <= cyc - last_ar;
                last_ar <= cyc;
            end
            if (r_pend && !r_stall) begin
                rvalid_q <= 1'b1; r_pend <= 1'b0;
            end
            if (rvalid_q && axi.m_axi_rready) rvalid_q <= 1'b0;
            if (cmd_clr) begin
                ar_n <= 0; last_ar <= -1; min_gap <= 1000000;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_cmd();
        @(negedge clk); cmd_clr = 1'b1;
        @(negedge clk); cmd_clr = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] m, output int acc);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
        @(negedge clk);
        acc = cyc - 1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int seen);
        int n = 0;
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
        seen = cyc;
    endtask

    task automatic release_rsp();
        @(negedge clk); rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0;
        chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, seen, b_aw, b_w, b_b, b_ar, n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valids", 32'({axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_bready,
                                 axi.m_axi_arvalid, axi.m_axi_rready, rsp_valid, rsp_timeout}), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        rst_n = 1'b1;

        // 1: zero-wait write, latency and beat contents, then read back
        b_b = b_hs;
        issue(OP_WRITE, GCP_TPC_BASE, 32'h0000_0400, 32'h0, acc);
        chk("busy_after_accept", 32'(busy), 32'd1);
        wait_rsp(seen);
        chk("wr_rsp_latency", 32'(seen - acc), 32'd3);
        chk("wr_aw_latency", 32'(aw_hs_cyc - acc), 32'd1);
        chk("wr_b_latency", 32'(b_hs_cyc - acc), 32'd2);
        chk("wr_awaddr", 32'(aw_a), 32'h100);
        chk("wr_wdata", w_d, 32'h0000_0400);
        chk("wr_wstrb", 32'(w_s), 32'hF);
        chk("wr_b_count", 32'(b_hs - b_b), 32'd1);
        chk("wr_rsp", {rsp_data[29:0], rsp_resp}, 32'd0);
        chk("wr_timeout", 32'(rsp_timeout), 32'd0);
        release_rsp();

        b_ar = ar_hs;
        issue(OP_READ, GCP_TPC_BASE, 32'h0, 32'h0, acc);
        wait_rsp(seen);
        chk("rd_data", rsp_data, 32'h0000_0400);
        chk("rd_resp", 32'(rsp_resp), 32'd0);
        chk("rd_ar_count", 32'(ar_hs - b_ar), 32'd1);
        release_rsp();

        issue(OP_RSVD, GCP_TPC_BASE, 32'h0, 32'h0, acc);
        wait_rsp(seen);
        chk("rsvd_as_read", rsp_data, 32'h0000_0400);
        release_rsp();

        // 2: AW accepted three cycles before W, SLVERR response
        aw_wait = 0; w_wait = 3; bresp_cfg = 2'b10;
        b_aw = aw_hs; b_w = w_hs; b_b = b_hs;
        issue(OP_WRITE, GCP_CTRL, 32'h0000_0001, 32'h0, acc);
        n = 0;
        while (aw_hs - b_aw < 1 && n < 50) begin @(negedge clk); n++; end
        chk("split_aw_done", 32'(aw_hs - b_aw), 32'd1);
        chk("split_awvalid_dropped", 32'(axi.m_axi_awvalid), 32'd0);
        chk("split_wvalid_held", 32'(axi.m_axi_wvalid), 32'd1);
        chk("split_w_pending", 32'(w_hs - b_w), 32'd0);
        wait_rsp(seen);
        chk("split_counts", 32'({8'(aw_hs - b_aw), 8'(w_hs - b_w), 8'(b_hs - b_b)}), 32'h010101);
        chk("split_bresp", 32'(rsp_resp), 32'd2);
        chk("split_data", rsp_data, 32'd0);
        release_rsp();
        w_wait = 0; bresp_cfg = 2'b00;

        // 3: poll STATUS bit16, set from the third read
        clear_cmd();
        status_set_at = 3;
        b_ar = ar_hs;
        issue(OP_POLL, GCP_STATUS, 32'h0001_0000, 32'h0001_0000, acc);
        wait_rsp(seen);
        chk("poll_ar_count", 32'(ar_hs - b_ar), 32'd3);
        chk("poll_gap_ok", 32'(min_gap >= PGAP + 2), 32'd1);
        chk("poll_data", rsp_data, 32'h0001_0003);
        chk("poll_timeout", 32'(rsp_timeout), 32'd0);
        chk("poll_resp", 32'(rsp_resp), 32'd0);
        release_rsp();

        // 4: bit never sets, exhaust POLL_MAX
        clear_cmd();
        status_set_at = 0;
        b_ar = ar_hs;
        issue(OP_POLL, GCP_STATUS, 32'h0001_0000, 32'h0001_0000, acc);
        wait_rsp(seen);
        chk("tmo_ar_count", 32'(ar_hs - b_ar), 32'd4);
        chk("tmo_timeout", 32'(rsp_timeout), 32'd1);
        chk("tmo_data", rsp_data, 32'h0000_0004);
        chk("tmo_resp", 32'(rsp_resp), 32'd0);
        release_rsp();

        // 5: second read answers DECERR
        clear_cmd();
        err_at = 2;
        b_ar = ar_hs;
        issue(OP_POLL, GCP_STATUS, 32'h0001_0000, 32'h0001_0000, acc);
        wait_rsp(seen);
        chk("err_ar_count", 32'(ar_hs - b_ar), 32'd2);
        chk("err_resp", 32'(rsp_resp), 32'd3);
        chk("err_timeout", 32'(rsp_timeout), 32'd0);
        chk("err_data", rsp_data, 32'h0000_0002);
        release_rsp();
        err_at = 0;

        // 6a: response held while rsp_ready is low
        issue(OP_READ, GCP_TPC_BASE, 32'h0, 32'h0, acc);
        wait_rsp(seen);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_data", rsp_data, 32'h0000_0400);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        release_rsp();

        // 6b: reset asserted while a poll waits for read data
        clear_cmd();
        r_stall = 1'b1;
        issue(OP_POLL, GCP_STATUS, 32'h0001_0000, 32'h0001_0000, acc);
        n = 0;
        while (!axi.m_axi_rready && n < 50) begin @(negedge clk); n++; end
        chk("mid_rd_data_reached", 32'(axi.m_axi_rready), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_arvalid", 32'(axi.m_axi_arvalid), 32'd0);
        chk("rst_rready", 32'(axi.m_axi_rready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        r_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        issue(OP_READ, GCP_TPC_BASE, 32'h0, 32'h0, acc);
        wait_rsp(seen);
        chk("post_rst_read", rsp_data, 32'h0000_0400);
        release_rsp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_host_master.md
Name: axil_host_master

Overview:
- AXI-Lite master that turns simple host-side commands into AXI-Lite transactions. Supported commands are write, read, and poll-until-match.
- It drives the accelerator's global command-processor register slave. Typical uses: program TPC start PCs, pulse global start, poll the all-done status bit.
- It is used by the FPGA bring-up sequencer and the system testbench in place of a real host CPU.
- One command is in flight at a time. Each command returns exactly one response.

Parameters:
- AXI_ADDR_W, 12, AXI address width.
- AXI_DATA_W, 32, AXI data width.
- POLL_MAX, 1024, maximum read attempts per poll command (>=1).
- POLL_GAP, 16, idle cycles between consecutive poll reads (>=0).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accept
- cmd_op  in  2  00=write, 01=read, 10=poll, 11=reserved (treated as read)
- cmd_addr  in  AXI_ADDR_W  register byte address
- cmd_data  in  AXI_DATA_W  write data (write) / expected value (poll)
- cmd_mask  in  AXI_DATA_W  poll compare mask (ignored otherwise)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  AXI_DATA_W  read data; 0 for writes
- rsp_resp  out  2  AXI BRESP/RRESP of the last beat
- rsp_timeout  out  1  poll exhausted POLL_MAX without match
- busy  out  1  state != IDLE
- m_axi_awaddr  out  AXI_ADDR_W  write address
- m_axi_awvalid  out  1  write address valid
- m_axi_awready  in  1  write address ready
- m_axi_wdata  out  AXI_DATA_W  write data
- m_axi_wstrb  out  AXI_DATA_W/8  write strobes, constant all ones
- m_axi_wvalid  out  1  write data valid
- m_axi_wready  in  1  write data ready
- m_axi_bresp  in  2  write response code
- m_axi_bvalid  in  1  write response valid
- m_axi_bready  out  1  write response ready
- m_axi_araddr  out  AXI_ADDR_W  read address
- m_axi_arvalid  out  1  read address valid
- m_axi_arready  in  1  read address ready
- m_axi_rdata  in  AXI_DATA_W  read data
- m_axi_rresp  in  2  read response code
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data ready

Behaviour:
- Reset: all registered outputs go to 0 asynchronously (awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_data, rsp_resp, rsp_timeout, addresses, wdata). State goes to IDLE.
- cmd_ready = (state==IDLE), combinational. busy = !cmd_ready.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, POLL_WAIT, RSP.
- IDLE:
  - On cmd_valid, latch op, addr, data and mask. Clear the attempt counter.
  - A write goes to WR with awvalid and wvalid both 1 in the next cycle.
  - A read or poll goes to RD_ADDR with arvalid 1 in the next cycle.
- WR:
  - awvalid and wvalid are held independently. Each drops in the cycle after its own handshake.
  - The AW and W handshakes may complete in the same cycle or in either order.
  - When both have completed, go to WR_RESP with bready=1.
- WR_RESP:
  - On bvalid&&bready: bready goes to 0, rsp_resp=bresp, rsp_data=0, rsp_timeout=0. Go to RSP.
- RD_ADDR:
  - arvalid is held until arready. Then arvalid goes to 0 and rready goes to 1. Go to RD_DATA.
  - attempt counter increments on each AR handshake.
- RD_DATA:
  - On rvalid&&rready: rready goes to 0, rsp_data=rdata, rsp_resp=rresp.
  - Read op: go to RSP.
  - Poll op, checked in priority order:
    1. rresp != 00: go to RSP with timeout=0.
    2. (rdata & mask) == (data & mask): go to RSP with timeout=0.
    3. attempts == POLL_MAX: go to RSP with rsp_timeout=1.
    4. Otherwise go to POLL_WAIT. If POLL_GAP==0, go directly to RD_ADDR.
- POLL_WAIT:
  - Count POLL_GAP cycles, then go to RD_ADDR.
  - Consecutive AR handshakes of one poll are therefore at least POLL_GAP+2 cycles apart.
- RSP:
  - rsp_valid=1. rsp_valid and all rsp_* outputs are stable until rsp_ready. Then rsp_valid goes to 0 and the state returns to IDLE.
  - The next cmd_ready is 1 in the cycle after the response handshake. There is no response bypass.
- Minimum write latency, with a zero-wait slave: cmd accept at N, AW/W handshake at N+1, B handshake at N+2, rsp_valid at N+3.
- Valid signals never drop before their handshake (AXI rule). The only exception is reset.
- A reset in the middle of a transaction clears everything immediately. Slave recovery is the system's responsibility.
- Address bits are not decoded. Unaligned addresses pass through unchanged.
- The attempt counter is $clog2(POLL_MAX+1) bits wide. The gap counter is $clog2(POLL_GAP+1) bits wide, minimum 1.

Decomposition:
- Shared package axil_pkg:
  - AXI resp codes: OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11.
  - cmd_op encodings.
  - State encoding.
  - The GCP register address constants (CTRL 0x000, STATUS 0x004, IRQ_EN 0x008, IRQ_STATUS 0x00C, TPC_BASE 0x100, TPC_STRIDE 0x010) for sequencer and benches.
- No sub-module. One FSM plus two counters.

Test Plan:
1. Write 0x100 with data 0x00000400 against the GCP → a single AW/W with wstrb=0xF and wdata 0x400, then one B. Response: resp=00, data=0, timeout=0. A following read of 0x100 returns rsp_data=0x00000400.
2. Slave model raises awready 3 cycles before wready → awvalid drops after its handshake while wvalid stays high until its own handshake. Exactly one B is received. With bresp=10, the response has rsp_resp=10.
3. Poll 0x004 with mask 0x00010000 and value 0x00010000, where STATUS bit16 sets before the 3rd read → exactly 3 AR handshakes, each at least POLL_GAP+2 cycles apart. Response: rsp_data bit16=1, timeout=0.
4. With POLL_MAX=4, poll a bit that never sets → 4 AR handshakes. Response: rsp_timeout=1, rsp_data=last rdata, resp=00.
5. Poll where the 2nd read returns rresp=11 → polling stops after 2 reads. Response: rsp_resp=11, timeout=0.
6. Hold rsp_ready low for 5 cycles → rsp_valid and rsp_data stay stable and cmd_ready=0. In a second run, assert rst_n low during RD_DATA of a poll → arvalid, rready and rsp_valid are 0 immediately and cmd_ready=1.
